// File: rtl/max_spi_slave_regs.sv
// SPI mode-0 slave register file answering the MAX3421E-style command protocol, oversampled in clk.
// Define MAX_SPI_SLV_STATUS_EN to return the status register on MISO during the command byte.
`timescale 1ns/1ps
module max_spi_slave_regs #(
    parameter int unsigned STAT_ADDR   = 25,
    parameter int unsigned IEN_ADDR    = 26,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_sclk,
    input  logic       spi_ss_n,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    input  logic [7:0] irq_set,
    input  logic [4:0] loc_addr,
    input  logic [7:0] loc_wdata,
    input  logic       loc_we,
    output logic [7:0] loc_rdata,
    output logic       spi_wr_stb,
    output logic [4:0] spi_wr_addr,
    output logic       int_o
);

    localparam logic [4:0] STAT_A = 5'(STAT_ADDR);
    localparam logic [4:0] IEN_A  = 5'(IEN_ADDR);

    typedef enum logic [1:0] {WAIT_IDLE, IDLE, CMD, DATA} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
    logic                   sclk_rise, sclk_fall, ss_now, ss_fall, mosi_s;
    logic [2:0]             bit_cnt;
    logic [6:0]             shift_in;
    logic [6:0]             shift_out;
    logic [7:0]             byte_in;
    logic [4:0]             addr;
    logic                   dir;
    logic                   load_pend;
    logic                   last_bit;
    logic                   spi_we;
    logic [7:0]             status_snap;
    logic [7:0]             regs      [32];
    logic [7:0]             regs_next [32];

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync <= '0;
            ss_sync   <= '0;
            mosi_sync <= '0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], spi_ss_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
        end
    end

    assign sclk_rise = sclk_sync[SYNC_STAGES-2] & ~sclk_sync[SYNC_STAGES-1];
    assign sclk_fall = ~sclk_sync[SYNC_STAGES-2] & sclk_sync[SYNC_STAGES-1];
    assign ss_now    = ss_sync[SYNC_STAGES-2];
    assign ss_fall   = ~ss_sync[SYNC_STAGES-2] & ss_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];

    assign byte_in  = {shift_in, mosi_s};
    assign last_bit = (bit_cnt == 3'd7);
    assign spi_we   = (state == DATA) && !ss_now && sclk_rise && last_bit && dir;

`ifdef MAX_SPI_SLV_STATUS_EN
    assign status_snap = regs[STAT_A];
`else
    assign status_snap = '0;
`endif

    // MISO bit for the next falling edge is held in spi_miso; shift_out keeps the remaining bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= WAIT_IDLE;
            bit_cnt     <= '0;
            shift_in    <= '0;
            shift_out   <= '0;
            addr        <= '0;
            dir         <= 1'b0;
            load_pend   <= 1'b0;
            spi_miso    <= 1'b0;
            spi_miso_oe <= 1'b0;
        end else begin
            spi_miso_oe <= !ss_now && (state != WAIT_IDLE);
            case (state)
                WAIT_IDLE: begin
                    spi_miso <= 1'b0;
                    if (ss_now) state <= IDLE;
                end
                IDLE: begin
                    bit_cnt   <= '0;
                    load_pend <= 1'b0;
                    if (ss_fall) begin
                        state                 <= CMD;
                        {spi_miso, shift_out} <= status_snap;
                    end else begin
                        spi_miso <= 1'b0;
                    end
                end
                default: begin
                    if (ss_now) begin
                        state     <= IDLE;
                        bit_cnt   <= '0;
                        load_pend <= 1'b0;
                        spi_miso  <= 1'b0;
                    end else begin
                        if (sclk_rise) begin
                            shift_in <= byte_in[6:0];
                            bit_cnt  <= bit_cnt + 3'd1;
                            if (last_bit) begin
                                load_pend <= 1'b1;
                                if (state == CMD) begin
                                    addr  <= byte_in[7:3];
                                    dir   <= byte_in[1];
                                    state <= DATA;
                                end
                            end
                        end
                        if (sclk_fall) begin
                            if (load_pend) begin
                                {spi_miso, shift_out} <= regs[addr];
                                load_pend             <= 1'b0;
                            end else begin
                                {spi_miso, shift_out} <= {shift_out, 1'b0};
                            end
                        end
                    end
                end
            endcase
        end
    end

    // SPI write beats the local port; irq_set is ORed in last so a same-clk set beats a W1C clear.
    always_comb begin
        for (int unsigned i = 0; i < 32; i++) begin
            regs_next[i] = regs[i];
            if (loc_we && loc_addr == 5'(i)) regs_next[i] = loc_wdata;
            if (spi_we && addr == 5'(i))
                regs_next[i] = (i == STAT_ADDR) ? (regs[i] & ~byte_in) : byte_in;
            if (i == STAT_ADDR) regs_next[i] = regs_next[i] | irq_set;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs        <= '{default: 8'h00};
            loc_rdata   <= '0;
            spi_wr_stb  <= 1'b0;
            spi_wr_addr <= '0;
            int_o       <= 1'b0;
        end else begin
            regs       <= regs_next;
            loc_rdata  <= regs[loc_addr];
            spi_wr_stb <= spi_we;
            if (spi_we) spi_wr_addr <= addr;
            int_o      <= |(regs[STAT_A] & regs[IEN_A]);
        end
    end

endmodule
